// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode encoding, FSM states,
// requester ids and the captured response record.
package alu_pkg;

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_RES = 3'b001;
    localparam logic [2:0] OP_PRO = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic        id;
        logic [15:0] result;
        logic        flag_a;
        logic        flag_b;
        logic        err;
    } rsp_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// Request/response bundle between two requesters, one consumer and the ALU arbiter.
interface alu_arbiter_ctrl_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_op;
    logic [7:0]  a_d0;
    logic [7:0]  a_d1;
    logic        b_valid;
    logic        b_ready;
    logic [2:0]  b_op;
    logic [7:0]  b_d0;
    logic [7:0]  b_d1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_flag_a;
    logic        rsp_flag_b;
    logic        rsp_err;
    logic [15:0] ops_done;

    modport slave (
        input  a_valid, a_op, a_d0, a_d1,
        input  b_valid, b_op, b_d0, b_d1,
        input  rsp_ready,
        output a_ready, b_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flag_a, rsp_flag_b, rsp_err, ops_done
    );

    modport master (
        output a_valid, a_op, a_d0, a_d1,
        output b_valid, b_op, b_d0, b_d1,
        output rsp_ready,
        input  a_ready, b_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flag_a, rsp_flag_b, rsp_err, ops_done
    );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU. Divide/modulo by zero yields 0 here only to keep
// the output defined; the controller never samples those cases.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    output logic [15:0] result,
    output logic        flag_a,
    output logic        flag_b
);

    // Opcode decode and datapath
    always_comb begin
        result = 16'h0000;
        case (op)
            OP_SUM:  result = {7'h00, ({1'b0, d0} + {1'b0, d1})};
            OP_RES:  result = {7'h00, ({1'b0, d0} - {1'b0, d1})};
            OP_PRO:  result = {8'h00, d0} * {8'h00, d1};
            OP_DIV: begin
                if (d1 != 8'h00) result = {8'h00, d0 / d1};
                else             result = 16'h0000;
            end
            OP_MOD: begin
                if (d1 != 8'h00) result = {8'h00, d0 % d1};
                else             result = 16'h0000;
            end
            OP_AND:  result = {8'h00, d0 & d1};
            OP_OR:   result = {8'h00, d0 | d1};
            OP_XOR:  result = {8'h00, d0 ^ d1};
            default: result = 16'h0000;
        endcase
    end

    // Carry/borrow only has meaning for add and subtract
    always_comb begin
        if ((op == OP_SUM) || (op == OP_RES)) flag_a = result[8];
        else                                  flag_a = 1'b0;
        flag_b = (result == 16'h0000);
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// multicycle settle window and a registered valid/ready response channel.
module alu_arbiter_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_arbiter_ctrl_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_e      state_r;
    state_e      state_s;
    logic        last_grant_r;
    logic        id_r;
    logic [2:0]  op_r;
    logic [7:0]  d0_r;
    logic [7:0]  d1_r;
    logic [3:0]  cnt_r;
    rsp_t        rsp_r;
    rsp_t        capture_s;
    logic [15:0] ops_done_r;
    logic        grant_a_s;
    logic        grant_b_s;
    logic        err_s;
    logic [15:0] alu_result_s;
    logic        alu_flag_a_s;
    logic        alu_flag_b_s;

    alu u_alu (
        .op     (op_r),
        .d0     (d0_r),
        .d1     (d1_r),
        .result (alu_result_s),
        .flag_a (alu_flag_a_s),
        .flag_b (alu_flag_b_s)
    );

    // Round-robin grant; gated by rst_n so nothing is accepted while in reset
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (bus.a_valid && (!bus.b_valid || (last_grant_r == ID_B))) grant_a_s = 1'b1;
            else                                                         grant_b_s = bus.b_valid;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Response record; DIV/MOD take only the result and rebuild zero themselves
    always_comb begin
        err_s            = is_div_op(op_r) && (d1_r == 8'h00);
        capture_s        = '0;
        capture_s.id     = id_r;
        if (err_s) begin
            capture_s.err = 1'b1;
        end else if (is_div_op(op_r)) begin
            capture_s.result = alu_result_s;
            capture_s.flag_b = (alu_result_s == 16'h0000);
        end else begin
            capture_s.result = alu_result_s;
            capture_s.flag_a = alu_flag_a_s;
            capture_s.flag_b = alu_flag_b_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s || grant_b_s) state_s = ST_EXEC;
                else                        state_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) state_s = ST_RESP;
                else               state_s = ST_EXEC;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_s = ST_IDLE;
                else               state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; last_grant starts at B so A wins the first contest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= ID_B;
        end else begin
            state_r <= state_s;
            if (grant_a_s)      last_grant_r <= ID_A;
            else if (grant_b_s) last_grant_r <= ID_B;
        end
    end

    // Operand latch at handshake; these are the only ALU inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r <= ID_A;
            op_r <= 3'b000;
            d0_r <= 8'h00;
            d1_r <= 8'h00;
        end else if (grant_a_s) begin
            id_r <= ID_A;
            op_r <= bus.a_op;
            d0_r <= bus.a_d0;
            d1_r <= bus.a_d1;
        end else if (grant_b_s) begin
            id_r <= ID_B;
            op_r <= bus.b_op;
            d0_r <= bus.b_d0;
            d1_r <= bus.b_d1;
        end
    end

    // Settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (grant_a_s || grant_b_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response capture and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_r      <= '0;
            ops_done_r <= 16'h0000;
        end else begin
            if ((state_r == ST_EXEC) && (cnt_r == 4'd0)) rsp_r <= capture_s;
            if ((state_r == ST_RESP) && bus.rsp_ready)    ops_done_r <= ops_done_r + 16'd1;
        end
    end

    assign bus.a_ready    = grant_a_s;
    assign bus.b_ready    = grant_b_s;
    assign bus.rsp_valid  = (state_r == ST_RESP);
    assign bus.rsp_id     = rsp_r.id;
    assign bus.rsp_result = rsp_r.result;
    assign bus.rsp_flag_a = rsp_r.flag_a;
    assign bus.rsp_flag_b = rsp_r.flag_b;
    assign bus.rsp_err    = rsp_r.err;
    assign bus.ops_done   = ops_done_r;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Scoreboard bench for alu_arbiter_ctrl: expected responses are queued at
// handshake time and compared when the DUT presents them.
module tb_alu_arbiter_ctrl;
    import alu_pkg::*;

    typedef struct packed {
        logic        id;
        logic [15:0] result;
        logic        fa;
        logic        fb;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_ctrl_if bus ();
    alu_arbiter_ctrl_if bus4 ();

    alu_arbiter_ctrl #(.EXEC_CYCLES(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_arbiter_ctrl #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int   tests_run = 0;
    int   failed    = 0;
    exp_t exp_q[$];

    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [7:0] d0, input logic [7:0] d1);
        exp_t        e;
        logic [16:0] w;
        e    = '0;
        e.id = id;
        w    = 17'h00000;
        case (op)
            OP_SUM: begin w = 17'(d0) + 17'(d1); e.result = w[15:0]; e.fa = w[8]; end
            OP_RES: begin w = 17'(d0) - 17'(d1); e.result = {7'h00, w[8:0]}; e.fa = w[8]; end
            OP_PRO: e.result = 16'(d0) * 16'(d1);
            OP_DIV: if (d1 == 8'h00) e.err = 1'b1; else e.result = 16'(d0 / d1);
            OP_MOD: if (d1 == 8'h00) e.err = 1'b1; else e.result = 16'(d0 % d1);
            OP_AND: e.result = 16'(d0 & d1);
            OP_OR:  e.result = 16'(d0 | d1);
            default: e.result = 16'(d0 ^ d1);
        endcase
        e.fb = !e.err && (e.result == 16'h0000);
        return e;
    endfunction

    function automatic exp_t observe();
        return {bus.rsp_id, bus.rsp_result, bus.rsp_flag_a, bus.rsp_flag_b, bus.rsp_err};
    endfunction

    // Drive one request and wait (bounded) for its handshake; returns #1 after the grant edge
    task automatic issue(input logic is_b, input logic [2:0] op, input logic [7:0] d0,
                         input logic [7:0] d1, output bit ok);
        ok = 1'b0;
        if (is_b) begin
            bus.b_valid = 1'b1; bus.b_op = op; bus.b_d0 = d0; bus.b_d1 = d1;
        end else begin
            bus.a_valid = 1'b1; bus.a_op = op; bus.a_d0 = d0; bus.a_d1 = d1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((is_b ? bus.b_ready : bus.a_ready) === 1'b1) begin
                exp_q.push_back(model(is_b, op, d0, d1));
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin @(posedge clk); #1; end
        if (is_b) bus.b_valid = 1'b0;
        else      bus.a_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, counting edges; pop the expected entry
    task automatic collect(output int lat, output exp_t e, output exp_t o, output bit ok);
        ok  = 1'b0;
        lat = 0;
        e   = '0;
        for (int i = 0; i < 60; i++) begin
            if (bus.rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        o = observe();
        if (ok && (exp_q.size() > 0)) e = exp_q.pop_front();
        else                          ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.rsp_ready = 1'b1;
        #12;
        tests_run++;
        if ({bus.a_ready, bus.b_ready, bus.rsp_valid, observe(), bus.ops_done} !== 39'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %h expected 0", {bus.a_ready, bus.b_ready, bus.rsp_valid, observe(), bus.ops_done});
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int   grants = 0;
        int   resps  = 0;
        logic exp_id;
        exp_t e, o;
        bus.a_op = OP_SUM; bus.a_d0 = 8'h12; bus.a_d1 = 8'h34;
        bus.b_op = OP_PRO; bus.b_d0 = 8'h10; bus.b_d1 = 8'h11;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.rsp_ready = 1'b1;
        for (int i = 0; (i < 100) && (resps < 4); i++) begin
            @(negedge clk);
            if ((bus.a_ready === 1'b1) || (bus.b_ready === 1'b1)) begin
                exp_id = (grants % 2 == 1) ? ID_B : ID_A;
                tests_run++;
                if ({bus.a_ready, bus.b_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                    failed++;
                    $display("FAIL rr_order: grant %0d got a/b ready %b%b expected id %0d", grants, bus.a_ready, bus.b_ready, exp_id);
                end
                if (exp_id) exp_q.push_back(model(ID_B, OP_PRO, 8'h10, 8'h11));
                else        exp_q.push_back(model(ID_A, OP_SUM, 8'h12, 8'h34));
                grants++;
            end
            if (bus.rsp_valid === 1'b1) begin
                o = observe();
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                tests_run++;
                if (o !== e) begin
                    failed++;
                    $display("FAIL rr_rsp%0d: got %h expected %h", resps, o, e);
                end
                resps++;
            end
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tests_run++;
        if (resps != 4) begin failed++; $display("FAIL rr_timeout: got %0d responses expected 4", resps); end
        @(posedge clk); #1;
        tests_run++;
        if (bus.ops_done !== 16'd4) begin failed++; $display("FAIL rr_ops_done: got %0d expected 4", bus.ops_done); end
    endtask

    task automatic test_single_sum();
        bit ok; int lat; exp_t e, o;
        bus.rsp_ready = 1'b1;
        issue(ID_A, OP_SUM, 8'hFF, 8'h01, ok);
        tests_run++;
        if (!ok) begin failed++; $display("FAIL sum_grant: got no a_ready expected grant"); end
        collect(lat, e, o, ok);
        tests_run++;
        if (!ok) begin failed++; $display("FAIL sum_rsp_timeout: got none expected response"); end
        tests_run++;
        if (lat !== 1) begin failed++; $display("FAIL sum_latency: got %0d expected 1", lat); end
        tests_run++;
        if ((o !== e) || (o !== {ID_A, 16'h0100, 1'b1, 1'b0, 1'b0})) begin
            failed++;
            $display("FAIL sum_rsp: got %h expected %h", o, e);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({bus.rsp_valid, bus.ops_done} !== {1'b0, 16'd5}) begin
            failed++;
            $display("FAIL sum_handshake: got valid %b ops %0d expected 0 5", bus.rsp_valid, bus.ops_done);
        end
    endtask

    task automatic test_div_err();
        bit ok; int lat; exp_t e, o;
        issue(ID_B, OP_DIV, 8'h10, 8'h00, ok);
        collect(lat, e, o, ok);
        tests_run++;
        if (!ok || (o !== e) || (o !== {ID_B, 16'h0000, 1'b0, 1'b0, 1'b1})) begin
            failed++;
            $display("FAIL div_zero: got %h expected %h", o, e);
        end
        @(posedge clk); #1;
        issue(ID_A, OP_DIV, 8'h10, 8'h03, ok);
        collect(lat, e, o, ok);
        tests_run++;
        if (!ok || (o !== e) || (o !== {ID_A, 16'h0005, 1'b0, 1'b0, 1'b0})) begin
            failed++;
            $display("FAIL div_ok: got %h expected %h", o, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit ok; int lat; exp_t e, o;
        bus.rsp_ready = 1'b0;
        issue(ID_A, OP_XOR, 8'h5A, 8'h0F, ok);
        bus.a_valid = 1'b1; bus.a_op = OP_SUM; bus.a_d0 = 8'h01; bus.a_d1 = 8'h02;
        collect(lat, e, o, ok);
        tests_run++;
        if (!ok || (o !== e)) begin failed++; $display("FAIL stall_rsp: got %h expected %h", o, e); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({bus.rsp_valid, bus.a_ready, observe()} !== {1'b1, 1'b0, e}) begin
                failed++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, {bus.rsp_valid, bus.a_ready, observe()}, {1'b1, 1'b0, e});
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.a_ready !== 1'b0) begin failed++; $display("FAIL stall_hs_grant: got a_ready %b expected 0", bus.a_ready); end
        @(posedge clk); #1;
        tests_run++;
        if ({bus.rsp_valid, bus.a_ready} !== 2'b01) begin
            failed++;
            $display("FAIL stall_after_hs: got valid/ready %b%b expected 01", bus.rsp_valid, bus.a_ready);
        end
        exp_q.push_back(model(ID_A, OP_SUM, 8'h01, 8'h02));
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        collect(lat, e, o, ok);
        tests_run++;
        if (!ok || (o !== e)) begin failed++; $display("FAIL stall_next: got %h expected %h", o, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_exec4();
        int   lat = 0;
        bit   seen = 1'b0;
        exp_t e, o;
        bus4.rsp_ready = 1'b1;
        bus4.a_valid = 1'b1; bus4.a_op = OP_PRO; bus4.a_d0 = 8'hFF; bus4.a_d1 = 8'hFF;
        e = model(ID_A, OP_PRO, 8'hFF, 8'hFF);
        @(negedge clk);
        tests_run++;
        if (bus4.a_ready !== 1'b1) begin failed++; $display("FAIL e4_grant: got %b expected 1", bus4.a_ready); end
        @(posedge clk); #1;
        bus4.a_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus4.rsp_valid === 1'b1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        o = {bus4.rsp_id, bus4.rsp_result, bus4.rsp_flag_a, bus4.rsp_flag_b, bus4.rsp_err};
        tests_run++;
        if (!seen || (lat !== 4)) begin failed++; $display("FAIL e4_latency: got %0d expected 4", lat); end
        tests_run++;
        if ((o !== e) || (o.result !== 16'hFE01) || (o.fb !== 1'b0)) begin
            failed++;
            $display("FAIL e4_rsp: got %h expected %h", o, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; exp_t e, o;
        bit leaked = 1'b0;
        bus.rsp_ready = 1'b1;
        issue(ID_A, OP_SUM, 8'h03, 8'h04, ok);
        #1;
        rst_n = 1'b0;
        bus.b_valid = 1'b1;
        #1;
        tests_run++;
        if ({bus.a_ready, bus.b_ready, bus.rsp_valid, observe(), bus.ops_done} !== 39'h0) begin
            failed++;
            $display("FAIL rst_mid_outputs: got %h expected 0", {bus.a_ready, bus.b_ready, bus.rsp_valid, observe(), bus.ops_done});
        end
        exp_q.delete();
        @(posedge clk); #1;
        bus.b_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0) leaked = 1'b1;
        end
        tests_run++;
        if (leaked) begin failed++; $display("FAIL rst_mid_leak: got rsp_valid 1 expected 0"); end
        bus.a_valid = 1'b1; bus.a_op = OP_AND; bus.a_d0 = 8'hF0; bus.a_d1 = 8'h3C;
        bus.b_valid = 1'b1; bus.b_op = OP_OR;  bus.b_d0 = 8'h01; bus.b_d1 = 8'h02;
        @(negedge clk);
        tests_run++;
        if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
            failed++;
            $display("FAIL rst_mid_first: got a/b ready %b%b expected 10", bus.a_ready, bus.b_ready);
        end
        exp_q.push_back(model(ID_A, OP_AND, 8'hF0, 8'h3C));
        @(posedge clk); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        collect(lat, e, o, ok);
        tests_run++;
        if (!ok || (o !== e)) begin failed++; $display("FAIL rst_mid_rsp: got %h expected %h", o, e); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_op = 3'b000; bus.a_d0 = 8'h00; bus.a_d1 = 8'h00;
        bus.b_valid = 1'b0; bus.b_op = 3'b000; bus.b_d0 = 8'h00; bus.b_d1 = 8'h00;
        bus.rsp_ready = 1'b0;
        bus4.a_valid = 1'b0; bus4.a_op = 3'b000; bus4.a_d0 = 8'h00; bus4.a_d1 = 8'h00;
        bus4.b_valid = 1'b0; bus4.b_op = 3'b000; bus4.b_d0 = 8'h00; bus4.b_d1 = 8'h00;
        bus4.rsp_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_single_sum();
        test_div_err();
        test_stall();
        test_exec4();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
